// File: rtl/instruction_fetch_pkg.sv
// Shared constants, IF/ID record type and PC helper for the fetch stage.
package instruction_fetch_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        valid;
  } ifid_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetch_if_skid_buffer.sv
// One-entry parking register for a ROM response that arrives while decode is held.
// Clear beats load, load beats unload.
module if_skid_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  logic [31:0] i_dat,
  input  logic [31:0] i_addr,
  output logic [31:0] o_dat,
  output logic [31:0] o_addr,
  output logic        o_full
);

  logic [31:0] r_dat;
  logic [31:0] r_addr;
  logic        r_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dat  <= '0;
      r_addr <= '0;
      r_full <= 1'b0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_dat  <= i_dat;
      r_addr <= i_addr;
      r_full <= 1'b1;
    end else if (i_unload) begin
      r_full <= 1'b0;
    end
  end

  assign o_dat  = r_dat;
  assign o_addr = r_addr;
  assign o_full = r_full;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches over a req/rvalid ROM handshake, drives IF/ID.
// FETCH_MISALIGN_EN: drop misaligned redirects and raise a sticky misalign_err.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = INST_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        hold,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic        rom_rvalid,
  input  logic [31:0] rom_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic        inst_valid,
  output logic        misalign_err
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HELD  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  localparam ifid_t BUBBLE = '{inst: NOP_INST, addr: 32'h0, valid: 1'b0};

  logic [1:0]  r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  ifid_t       r_ifid, w_ifid_nxt;
  // Gates rom_req for the first cycle after reset release.
  logic        r_active;

  logic        w_jump;
  logic [31:0] w_target;
  logic        w_req;
  logic        w_skid_load, w_skid_unload, w_skid_clear;
  logic [31:0] w_skid_dat, w_skid_addr;
  logic        w_skid_full;

`ifdef FETCH_MISALIGN_EN
  logic w_misalign;
  logic r_misalign_err;

  assign w_misalign = jump_en && (jump_addr[1:0] != 2'b00);
  assign w_jump     = jump_en && !w_misalign;
  assign w_target   = jump_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_misalign_err <= 1'b0;
    else if (w_misalign) r_misalign_err <= 1'b1;
  end
  assign misalign_err = r_misalign_err;
`else
  assign w_jump       = jump_en;
  assign w_target     = jump_addr & 32'hFFFF_FFFC;
  assign misalign_err = 1'b0;
`endif

  assign w_req    = r_active && (r_state == ST_FETCH);
  assign rom_req  = w_req;
  assign rom_addr = r_pc;

  if_skid_buffer u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (w_skid_clear),
    .i_dat    (rom_rdata),
    .i_addr   (r_pc),
    .o_dat    (w_skid_dat),
    .o_addr   (w_skid_addr),
    .o_full   (w_skid_full)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ifid_nxt    = r_ifid;
    w_skid_load   = 1'b0;
    w_skid_unload = 1'b0;
    w_skid_clear  = 1'b0;

    if (w_jump) begin
      w_pc_nxt     = w_target;
      w_ifid_nxt   = BUBBLE;
      w_skid_clear = 1'b1;
      case (r_state)
        ST_FETCH: w_state_nxt = (w_req && !rom_rvalid) ? ST_DROP : ST_FETCH;
        ST_DROP:  w_state_nxt = rom_rvalid ? ST_FETCH : ST_DROP;
        default:  w_state_nxt = ST_FETCH;
      endcase
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_req && rom_rvalid) begin
            w_pc_nxt = pc_inc(r_pc);
            if (hold) begin
              w_skid_load = 1'b1;
              w_state_nxt = ST_HELD;
            end else begin
              w_ifid_nxt = '{inst: rom_rdata, addr: r_pc, valid: 1'b1};
            end
          end else if (!hold) begin
            w_ifid_nxt = BUBBLE;
          end
        end
        ST_HELD: begin
          if (!hold) begin
            w_ifid_nxt    = '{inst: w_skid_dat, addr: w_skid_addr, valid: w_skid_full};
            w_skid_unload = 1'b1;
            w_state_nxt   = ST_FETCH;
          end
        end
        ST_DROP: begin
          if (rom_rvalid) w_state_nxt = ST_FETCH;
          if (!hold)      w_ifid_nxt  = BUBBLE;
        end
        default: w_state_nxt = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_FETCH;
      r_pc     <= RESET_PC;
      r_ifid   <= BUBBLE;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ifid   <= w_ifid_nxt;
      r_active <= 1'b1;
    end
  end

  assign inst       = r_ifid.inst;
  assign inst_addr  = r_ifid.addr;
  assign inst_valid = r_ifid.valid;

endmodule
